// File: rtl/bcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_pkg : shared types and constants for the binary<->BCD converter |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic       MODE_B2B   = 1'b0;
   localparam logic       MODE_B2BIN = 1'b1;
   localparam logic [3:0] ADD_TH     = 4'd5;
   localparam logic [3:0] SUB_TH     = 4'd8;
   localparam logic [3:0] ADJ        = 4'd3;

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_digit_adjust : per-nibble +3 (dir=0) / -3 (dir=1) correction   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module bcd_digit_adjust
   import bcd_pkg::*;
#(
   parameter int DIGITS = 5
) (
   input  logic [4*DIGITS-1:0] bcd_in,
   input  logic                dir,
   output logic [4*DIGITS-1:0] bcd_out
);

   // Nibbles are adjusted independently; the ranges used never produce a carry or borrow.
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      logic [3:0] w_digit;
      assign w_digit = bcd_in[4*g +: 4];
      assign bcd_out[4*g +: 4] =
         (dir == MODE_B2B) ? ((w_digit >= ADD_TH) ? w_digit + ADJ : w_digit)
                           : ((w_digit >= SUB_TH) ? w_digit - ADJ : w_digit);
   end

endmodule
`default_nettype wire

// File: rtl/bcd_bin_converter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_bin_converter : iterative bidirectional binary<->BCD converter |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module bcd_bin_converter
   import bcd_pkg::*;
#(
   parameter  int BIN_W  = 16,
   parameter  int DIGITS = 5,
   localparam int DW     = max_w(BIN_W, 4*DIGITS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          mode,
   input  logic [DW-1:0] data_in,
   output logic [DW-1:0] data_out,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int BW = 4*DIGITS;
   localparam int WW = BW + BIN_W;
   localparam int CW = $clog2(BIN_W+1);

   state_t          r_state;
   logic [WW-1:0]   r_work;
   logic [CW-1:0]   r_cnt;
   logic            r_mode;
   logic            r_ovf;
   logic [DW-1:0]   r_data_out;
   logic            r_busy;
   logic            r_done;
   logic            r_err;

   logic [WW-1:0]   w_shifted;
   logic [BW-1:0]   w_adj_in;
   logic [BW-1:0]   w_adj_out;
   logic [WW-1:0]   w_work_next;
   logic            w_ovf_next;
   logic            w_range_err;
   logic            w_digit_bad;
   logic [DW-1:0]   w_bcd_res;
   logic [DW-1:0]   w_bin_res;

   // BCD->binary adjusts after the right shift, binary->BCD adjusts before the left shift.
   always_comb begin
      w_shifted = r_work >> 1;
      w_adj_in  = (r_mode == MODE_B2BIN) ? w_shifted[WW-1:BIN_W] : r_work[WW-1:BIN_W];
   end

   bcd_digit_adjust #(.DIGITS(DIGITS)) u_adjust (
      .bcd_in  (w_adj_in),
      .dir     (r_mode),
      .bcd_out (w_adj_out)
   );

   always_comb begin
      if (r_mode == MODE_B2BIN)
         w_work_next = {w_adj_out, w_shifted[BIN_W-1:0]};
      else
         w_work_next = {w_adj_out[BW-2:0], r_work[BIN_W-1:0], 1'b0};
      w_ovf_next  = r_ovf | ((r_mode == MODE_B2B) & w_adj_out[BW-1]);
      w_range_err = |w_work_next[WW-1:BIN_W];
      w_bcd_res   = '0;
      w_bcd_res[BW-1:0] = w_work_next[WW-1:BIN_W];
      w_bin_res   = '0;
      w_bin_res[BIN_W-1:0] = w_work_next[BIN_W-1:0];
      w_digit_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (data_in[4*i +: 4] > 4'd9)
            w_digit_bad = 1'b1;
   end

   // The final iteration and the FIN transition share an edge so done lands BIN_W+1 cycles out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_work     <= '0;
         r_cnt      <= '0;
         r_mode     <= MODE_B2B;
         r_ovf      <= 1'b0;
         r_data_out <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_busy <= 1'b1;
                  r_mode <= mode;
                  r_ovf  <= 1'b0;
                  r_cnt  <= CW'(BIN_W);
                  if (mode == MODE_B2BIN && w_digit_bad) begin
                     r_data_out <= '0;
                     r_err      <= 1'b1;
                     r_done     <= 1'b1;
                     r_state    <= FIN;
                  end else begin
                     r_work  <= (mode == MODE_B2BIN) ? {data_in[BW-1:0], {BIN_W{1'b0}}}
                                                     : {{BW{1'b0}}, data_in[BIN_W-1:0]};
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               r_work <= w_work_next;
               r_ovf  <= w_ovf_next;
               r_cnt  <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state    <= FIN;
                  r_done     <= 1'b1;
                  r_data_out <= (r_mode == MODE_B2BIN) ? w_bin_res : w_bcd_res;
                  r_err      <= (r_mode == MODE_B2BIN) ? w_range_err : w_ovf_next;
               end
            end
            FIN: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign data_out = r_data_out;
   assign busy     = r_busy;
   assign done     = r_done;
   assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_bin_converter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bcd_bin_converter : directed bench for three converter configs  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_bcd_bin_converter;

   logic        clk;
   logic        reset;
   logic        start0, mode0, start1, mode1, start2, mode2;
   logic [19:0] din0, dout0;
   logic [11:0] din1, dout1;
   logic [7:0]  din2, dout2;
   logic        busy0, done0, err0;
   logic        busy1, done1, err1;
   logic        busy2, done2, err2;

   int errors = 0;
   int checks = 0;

   bcd_bin_converter #(.BIN_W(16), .DIGITS(5)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .mode(mode0), .data_in(din0),
      .data_out(dout0), .busy(busy0), .done(done0), .err(err0));
   bcd_bin_converter #(.BIN_W(8), .DIGITS(3)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .mode(mode1), .data_in(din1),
      .data_out(dout1), .busy(busy1), .done(done1), .err(err1));
   bcd_bin_converter #(.BIN_W(8), .DIGITS(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .mode(mode2), .data_in(din2),
      .data_out(dout2), .busy(busy2), .done(done2), .err(err2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; returns at the negedge of the done cycle (lat = cycles after accept).
   task automatic op0(input logic m, input logic [19:0] d,
                      output logic [19:0] q, output logic e, output int lat);
      start0 = 1'b1; mode0 = m; din0 = d;
      @(negedge clk);
      start0 = 1'b0; mode0 = ~m; din0 = 20'hFFFFF;
      lat = -1; q = '0; e = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (done0 === 1'b1) begin lat = k; q = dout0; e = err0; break; end
         @(negedge clk);
      end
   endtask

   task automatic op1(input logic m, input logic [11:0] d,
                      output logic [11:0] q, output logic e, output int lat);
      start1 = 1'b1; mode1 = m; din1 = d;
      @(negedge clk);
      start1 = 1'b0; din1 = '0;
      lat = -1; q = '0; e = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (done1 === 1'b1) begin lat = k; q = dout1; e = err1; break; end
         @(negedge clk);
      end
   endtask

   task automatic op2(input logic m, input logic [7:0] d,
                      output logic [7:0] q, output logic e, output int lat);
      start2 = 1'b1; mode2 = m; din2 = d;
      @(negedge clk);
      start2 = 1'b0; din2 = '0;
      lat = -1; q = '0; e = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (done2 === 1'b1) begin lat = k; q = dout2; e = err2; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start0 = 0; mode0 = 0; din0 = '0;
      start1 = 0; mode1 = 0; din1 = '0;
      start2 = 0; mode2 = 0; din2 = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy0, done0, err0, dout0} !== 23'd0) begin
         errors++; $display("FAIL reset_state: got busy=%b done=%b err=%b out=%h required all 0", busy0, done0, err0, dout0);
      end
      checks++;
      if ({busy1, done1, busy2, done2} !== 4'd0) begin
         errors++; $display("FAIL reset_small: got %b required 0000", {busy1, done1, busy2, done2});
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_bin2bcd();
      logic [19:0] q; logic e; int lat;
      op0(1'b0, 20'd65535, q, e, lat);
      checks++;
      if (q !== 20'h65535 || e !== 1'b0) begin
         errors++; $display("FAIL b2bcd_65535: got %h err=%b required 65535 err=0", q, e);
      end
      checks++;
      if (lat !== 17) begin errors++; $display("FAIL b2bcd_latency: got %0d required 17", lat); end
      checks++;
      if (busy0 !== 1'b1) begin errors++; $display("FAIL busy_in_done: got %b required 1", busy0); end
      @(negedge clk);
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0) begin
         errors++; $display("FAIL after_done: got busy=%b done=%b required 0 0", busy0, done0);
      end
      op0(1'b0, 20'd1234, q, e, lat);
      @(negedge clk);
      checks++;
      if (q !== 20'h01234 || e !== 1'b0) begin
         errors++; $display("FAIL b2bcd_1234: got %h err=%b required 01234 err=0", q, e);
      end
   endtask

   task automatic test_bcd2bin();
      logic [19:0] q; logic e; int lat;
      op0(1'b1, 20'h12345, q, e, lat);
      @(negedge clk);
      checks++;
      if (q !== 20'h03039 || e !== 1'b0 || lat !== 17) begin
         errors++; $display("FAIL bcd2bin_12345: got %h err=%b lat=%0d required 03039 err=0 lat=17", q, e, lat);
      end
      op0(1'b1, 20'h65535, q, e, lat);
      @(negedge clk);
      checks++;
      if (q !== 20'h0FFFF || e !== 1'b0) begin
         errors++; $display("FAIL bcd2bin_65535: got %h err=%b required 0ffff err=0", q, e);
      end
      op0(1'b1, 20'h65536, q, e, lat);
      @(negedge clk);
      checks++;
      if (q !== 20'h00000 || e !== 1'b1) begin
         errors++; $display("FAIL bcd2bin_65536: got %h err=%b required 00000 err=1", q, e);
      end
      op0(1'b1, 20'h99999, q, e, lat);
      @(negedge clk);
      checks++;
      if (q !== 20'h0869F || e !== 1'b1) begin
         errors++; $display("FAIL bcd2bin_99999: got %h err=%b required 0869f err=1", q, e);
      end
   endtask

   task automatic test_invalid_digit();
      logic [19:0] q; logic e; int lat;
      op0(1'b1, 20'h1A345, q, e, lat);
      checks++;
      if (q !== 20'h00000 || e !== 1'b1 || lat !== 1) begin
         errors++; $display("FAIL invalid_digit: got %h err=%b lat=%0d required 00000 err=1 lat=1", q, e, lat);
      end
      @(negedge clk);
      op0(1'b1, 20'h00042, q, e, lat);
      @(negedge clk);
      checks++;
      if (q !== 20'h0002A || e !== 1'b0) begin
         errors++; $display("FAIL err_clears: got %h err=%b required 0002a err=0", q, e);
      end
   endtask

   task automatic test_ignore_start();
      logic [19:0] q; logic e; int lat; int extra;
      start0 = 1'b1; mode0 = 1'b0; din0 = 20'd65535;
      @(negedge clk);
      lat = -1; q = '0; e = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         start0 = (k == 5); mode0 = 1'b1; din0 = 20'h12345;
         if (done0 === 1'b1) begin lat = k; q = dout0; e = err0; break; end
         @(negedge clk);
      end
      start0 = 1'b0;
      checks++;
      if (q !== 20'h65535 || e !== 1'b0 || lat !== 17) begin
         errors++; $display("FAIL start_mid_run: got %h err=%b lat=%0d required 65535 err=0 lat=17", q, e, lat);
      end
      // A start in the done cycle must not launch a conversion either.
      start0 = 1'b1; mode0 = 1'b0; din0 = 20'd7;
      @(negedge clk);
      start0 = 1'b0;
      extra = 0;
      for (int k = 0; k < 20; k++) begin
         if (busy0 !== 1'b0 || done0 !== 1'b0) extra++;
         @(negedge clk);
      end
      checks++;
      if (extra !== 0 || dout0 !== 20'h65535) begin
         errors++; $display("FAIL start_ignored: got %0d busy cycles out=%h required 0 out=65535", extra, dout0);
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] q; logic e; int lat;
      op0(1'b0, 20'd9999, q, e, lat);
      @(negedge clk);
      checks++;
      if (q !== 20'h09999 || busy0 !== 1'b0) begin
         errors++; $display("FAIL b2b_first: got %h busy=%b required 09999 busy=0", q, busy0);
      end
      op0(1'b1, 20'h00255, q, e, lat);
      checks++;
      if (q !== 20'h000FF || e !== 1'b0 || lat !== 17) begin
         errors++; $display("FAIL b2b_second: got %h err=%b lat=%0d required 000ff err=0 lat=17", q, e, lat);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      logic [19:0] q; logic e; int lat; int seen;
      start0 = 1'b1; mode0 = 1'b0; din0 = 20'd4321;
      @(negedge clk);
      start0 = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || dout0 !== 20'h0) begin
         errors++; $display("FAIL reset_mid_run: got busy=%b done=%b out=%h required 0 0 0", busy0, done0, dout0);
      end
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      for (int k = 0; k < 25; k++) begin
         if (done0 === 1'b1 || busy0 === 1'b1) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL no_done_after_reset: got %0d active cycles required 0", seen); end
      op0(1'b0, 20'd0, q, e, lat);
      @(negedge clk);
      checks++;
      if (q !== 20'h00000 || e !== 1'b0 || lat !== 17) begin
         errors++; $display("FAIL zero_after_reset: got %h err=%b lat=%0d required 00000 err=0 lat=17", q, e, lat);
      end
   endtask

   task automatic test_small_widths();
      logic [11:0] q1; logic [7:0] q2; logic e; int lat;
      op1(1'b0, 12'd255, q1, e, lat);
      @(negedge clk);
      checks++;
      if (q1 !== 12'h255 || e !== 1'b0 || lat !== 9) begin
         errors++; $display("FAIL w8d3_255: got %h err=%b lat=%0d required 255 err=0 lat=9", q1, e, lat);
      end
      op2(1'b0, 8'd255, q2, e, lat);
      @(negedge clk);
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL w8d2_ovf: got err=%b required 1", e); end
      op2(1'b0, 8'd99, q2, e, lat);
      @(negedge clk);
      checks++;
      if (q2 !== 8'h99 || e !== 1'b0) begin
         errors++; $display("FAIL w8d2_99: got %h err=%b required 99 err=0", q2, e);
      end
      op2(1'b1, 8'h99, q2, e, lat);
      @(negedge clk);
      checks++;
      if (q2 !== 8'h63 || e !== 1'b0) begin
         errors++; $display("FAIL w8d2_bcd99: got %h err=%b required 63 err=0", q2, e);
      end
   endtask

   initial begin
      test_reset();
      test_bin2bcd();
      test_bcd2bin();
      test_invalid_digit();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
      test_small_widths();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
